// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle for the byte-addressable data memory.
// Handshake: a request is taken on any rising edge where req=1 and busy=0; there is no ready, so
// the master never stalls. Each taken request yields exactly one of: a store (silent), r_valid
// (load data in r_data), or err, all one cycle after the request edge.
interface data_mem_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              w_en;
    logic [1:0]        size;
    logic              sign_ext;
    logic [31:0]       addr;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              err;
    logic              busy;
    logic [DATA_W-1:0] test_value;
    logic              state_dbg;

    modport master (
        output req, w_en, size, sign_ext, addr, w_data,
        input  r_data, r_valid, err, busy, test_value, state_dbg
    );

    modport slave (
        input  req, w_en, size, sign_ext, addr, w_data,
        output r_data, r_valid, err, busy, test_value, state_dbg
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressable MIPS data memory: byte/half/word access, sign/zero-extended registered loads,
// alignment and range rejection, and a post-reset sequencer that zeroes one word per cycle.
module data_mem_ctrl #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 256,
    parameter int TEST_IDX = 0
) (
    input logic           clk,
    input logic           reset,
    data_mem_ctrl_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic              r_valid_q, r_valid_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        bo;
    logic [29:0]       wi;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              misaligned;
    logic              reject;
    logic              do_store;
    logic              do_load;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wlanes;
    logic [DATA_W-1:0] rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [DATA_W-1:0] load_val;

    assign bo       = bus.addr[1:0];
    assign wi       = bus.addr[31:2];
    assign idx      = bus.addr[IDX_W+1:2];
    assign in_range = ({2'b00, wi} < 32'(DEPTH));

    always_comb begin
        misaligned = 1'b1;
        case (bus.size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = bo[0];
            2'b10:   misaligned = (bo != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    assign reject   = misaligned || !in_range;
    assign do_store = (state_q == S_IDLE) && bus.req && !reject && bus.w_en;
    assign do_load  = (state_q == S_IDLE) && bus.req && !reject && !bus.w_en;

    // Clear sequencer: one word per cycle, leaves for IDLE after writing the last index.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            S_CLEAR: begin
                if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d   = S_IDLE;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            S_IDLE:  state_d = S_IDLE;
            default: state_d = S_CLEAR;
        endcase
    end

    // Narrow stores replicate the payload across the word so each enabled lane sees its bytes.
    always_comb begin
        be     = '1;
        wlanes = bus.w_data;
        case (bus.size)
            2'b00: begin
                be     = NB'(1) << bo;
                wlanes = {NB{bus.w_data[7:0]}};
            end
            2'b01: begin
                be     = NB'(3) << bo;
                wlanes = {(NB / 2){bus.w_data[15:0]}};
            end
            default: begin
                be     = '1;
                wlanes = bus.w_data;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem[clr_idx_q] <= '0;
        end else if (do_store) begin
            for (int l = 0; l < NB; l++) begin
                if (be[l]) mem[idx][8*l +: 8] <= wlanes[8*l +: 8];
            end
        end
    end

    assign rd_word = mem[idx];
    assign rd_byte = rd_word[{bo, 3'b000} +: 8];
    assign rd_half = rd_word[{bo[1], 4'b0000} +: 16];

    always_comb begin
        load_val = rd_word;
        case (bus.size)
            2'b00: load_val = bus.sign_ext ? {{(DATA_W-8){rd_byte[7]}}, rd_byte}
                                           : {{(DATA_W-8){1'b0}}, rd_byte};
            2'b01: load_val = bus.sign_ext ? {{(DATA_W-16){rd_half[15]}}, rd_half}
                                           : {{(DATA_W-16){1'b0}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    always_comb begin
        r_valid_d = do_load;
        err_d     = (state_q == S_IDLE) && bus.req && reject;
        r_data_d  = do_load ? load_val : r_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            r_data_q  <= r_data_d;
            r_valid_q <= r_valid_d;
            err_q     <= err_d;
        end
    end

    assign bus.r_data     = r_data_q;
    assign bus.r_valid    = r_valid_q;
    assign bus.err        = err_q;
    assign bus.busy       = (state_q == S_CLEAR);
    assign bus.test_value = (state_q == S_CLEAR) ? '0 : mem[TEST_IDX];
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed scenarios plus random traffic against a byte-array model.
module tb_data_mem_ctrl;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 256;
  localparam int TEST_IDX = 0;

  logic clk = 1'b0;
  logic reset = 1'b0;

  data_mem_ctrl_if #(.DATA_W(DATA_W)) bus();

  data_mem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TEST_IDX(TEST_IDX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]        mm [DEPTH*4];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] last_rd = '0;

  // ---------------- reference model (byte array, little-endian) ----------------
  function automatic int nbytes_of(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic bit model_reject(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b1;
    if ((a % nbytes_of(sz)) != 0) return 1'b1;
    return (a >= 32'(DEPTH * 4));
  endfunction

  function automatic void model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    for (int k = 0; k < nbytes_of(sz); k++) mm[a + 32'(k)] = 8'((wd >> (8 * k)) & 32'hFF);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sx, input logic [31:0] a);
    longint v = 0;
    int n = nbytes_of(sz);
    for (int k = 0; k < n; k++) v += longint'(mm[a + 32'(k)]) << (8 * k);
    if (n < 4 && sx && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_tv();
    return {mm[TEST_IDX*4+3], mm[TEST_IDX*4+2], mm[TEST_IDX*4+1], mm[TEST_IDX*4]};
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH * 4; i++) mm[i] = 8'h00;
    last_rd = '0;
    exp_q.delete();
  endfunction

  // ---------------- driver: one request per call, one clock per call ----------------
  task automatic issue(input bit rq, input bit we, input logic [1:0] sz, input bit sx,
                       input logic [31:0] a, input logic [31:0] wd,
                       output bit e_err, output bit e_vld, output logic [31:0] e_rd);
    bit rej;
    bus.req = rq; bus.w_en = we; bus.size = sz; bus.sign_ext = sx; bus.addr = a; bus.w_data = wd;
    rej   = model_reject(sz, a);
    e_err = rq && rej;
    e_vld = rq && !rej && !we;
    if (e_vld) exp_q.push_back(model_load(sz, sx, a));
    if (rq && !rej && we) model_store(sz, a, wd);
    @(posedge clk); #1;
    bus.req = 1'b0;
    if (e_vld) last_rd = exp_q.pop_front();
    e_rd = last_rd;
  endtask

  // Called right after reset is released on a negedge; counts edges until busy drops.
  task automatic count_clear(output int n, output int stray);
    n = 0;
    stray = 0;
    forever begin
      bus.req = 1'b1; bus.w_en = 1'($urandom_range(0, 1)); bus.size = 2'b10;
      bus.sign_ext = 1'b0; bus.addr = 32'h0; bus.w_data = 32'hFFFF_FFFF;
      @(posedge clk); n++; #1;
      if (bus.r_valid !== 1'b0 || bus.err !== 1'b0 || bus.test_value !== '0) stray++;
      if (!bus.busy || n >= 1000) break;
    end
    bus.req = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int n, stray;
    bit e_err, e_vld;
    logic [31:0] e_rd;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b1 || bus.r_valid !== 1'b0 || bus.err !== 1'b0 || bus.r_data !== '0) begin
      bad++;
      $display("FAIL reset_state: busy=%b r_valid=%b err=%b r_data=%h, want 1 0 0 00000000",
               bus.busy, bus.r_valid, bus.err, bus.r_data);
    end
    @(negedge clk) reset = 1'b1;
    count_clear(n, stray);
    model_clear();
    total++;
    if (n != 256) begin bad++; $display("FAIL busy_len: got %0d cycles, want 256", n); end
    total++;
    if (stray != 0) begin bad++; $display("FAIL req_while_busy: %0d cycles with output activity, want 0", stray); end
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, 1'b0, 2'b10, 1'b0, (i == 0) ? 32'h0 : 32'h3FC, 32'h0, e_err, e_vld, e_rd);
      total++;
      if (bus.r_valid !== 1'b1 || bus.err !== 1'b0 || bus.r_data !== 32'h0) begin
        bad++;
        $display("FAIL cleared_load%0d: r_valid=%b err=%b r_data=%h, want 1 0 00000000",
                 i, bus.r_valid, bus.err, bus.r_data);
      end
    end
  endtask

  task automatic test_byte_loads();
    logic [31:0] tbl_s [4] = '{32'hFFFF_FFEF, 32'hFFFF_FFBE, 32'hFFFF_FFAD, 32'hFFFF_FFDE};
    logic [31:0] tbl_z [4] = '{32'h0000_00EF, 32'h0000_00BE, 32'h0000_00AD, 32'h0000_00DE};
    bit e_err, e_vld;
    logic [31:0] e_rd, want;
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, e_err, e_vld, e_rd);
    total++;
    if (bus.r_valid !== 1'b0 || bus.err !== 1'b0) begin
      bad++; $display("FAIL store_word_quiet: r_valid=%b err=%b, want 0 0", bus.r_valid, bus.err);
    end
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 4; k++) begin
        issue(1'b1, 1'b0, 2'b00, (s == 0), 32'h10 + 32'(k), 32'h0, e_err, e_vld, e_rd);
        want = (s == 0) ? tbl_s[k] : tbl_z[k];
        total++;
        if (bus.r_valid !== 1'b1 || bus.err !== 1'b0 || bus.r_data !== want || bus.r_data !== e_rd) begin
          bad++;
          $display("FAIL byte_load sx=%0d off=%0d: r_valid=%b err=%b r_data=%h, want 1 0 %h",
                   (s == 0), k, bus.r_valid, bus.err, bus.r_data, want);
        end
      end
    end
  endtask

  task automatic test_merge();
    bit          t_we [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  t_sz [5] = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b01};
    logic [31:0] t_a  [5] = '{32'h12, 32'h10, 32'h11, 32'h10, 32'h10};
    logic [31:0] t_wd [5] = '{32'h1234, 32'h0, 32'h80, 32'h0, 32'h0};
    logic [31:0] t_ex [5] = '{32'h0, 32'h1234_BEEF, 32'h0, 32'h1234_80EF, 32'hFFFF_80EF};
    bit e_err, e_vld;
    logic [31:0] e_rd;
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, t_we[i], t_sz[i], 1'b1, t_a[i], t_wd[i], e_err, e_vld, e_rd);
      total++;
      if (bus.err !== 1'b0 || bus.r_valid !== !t_we[i] || (!t_we[i] && bus.r_data !== t_ex[i])
          || bus.r_data !== e_rd) begin
        bad++;
        $display("FAIL merge step%0d: r_valid=%b err=%b r_data=%h, want %b 0 %h",
                 i, bus.r_valid, bus.err, bus.r_data, !t_we[i], t_we[i] ? e_rd : t_ex[i]);
      end
    end
  endtask

  task automatic test_errors();
    bit          t_we [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  t_sz [6] = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b10, 2'b10};
    logic [31:0] t_a  [6] = '{32'h2, 32'h1, 32'h0, 32'h0, 32'h400, 32'h400};
    bit e_err, e_vld;
    logic [31:0] e_rd, held;
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0BAD_F00D, e_err, e_vld, e_rd);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h3, 32'h0, e_err, e_vld, e_rd);
    held = 32'h0000_000B;
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, t_we[i], t_sz[i], 1'b0, t_a[i], 32'hFFFF_FFFF, e_err, e_vld, e_rd);
      total++;
      if (bus.err !== 1'b1 || bus.r_valid !== 1'b0 || bus.r_data !== held || e_rd !== held) begin
        bad++;
        $display("FAIL reject%0d: err=%b r_valid=%b r_data=%h, want 1 0 %h",
                 i, bus.err, bus.r_valid, bus.r_data, held);
      end
    end
    issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, e_err, e_vld, e_rd);
    total++;
    if (bus.err !== 1'b0 || bus.r_valid !== 1'b0) begin
      bad++; $display("FAIL err_pulse_len: err=%b r_valid=%b, want 0 0", bus.err, bus.r_valid);
    end
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, e_err, e_vld, e_rd);
    total++;
    if (bus.r_valid !== 1'b1 || bus.r_data !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL reject_no_write: r_valid=%b r_data=%h, want 1 0badf00d", bus.r_valid, bus.r_data);
    end
  endtask

  task automatic test_test_value();
    bit e_err, e_vld;
    logic [31:0] e_rd;
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'hA5A5_A5A5, e_err, e_vld, e_rd);
    total++;
    if (bus.test_value !== 32'hA5A5_A5A5) begin
      bad++; $display("FAIL test_value_word: got %h, want a5a5a5a5", bus.test_value);
    end
    issue(1'b1, 1'b1, 2'b00, 1'b0, 32'h2, 32'h3C, e_err, e_vld, e_rd);
    total++;
    if (bus.test_value !== model_tv() || bus.test_value !== 32'hA53C_A5A5) begin
      bad++; $display("FAIL test_value_byte: got %h, want a53ca5a5", bus.test_value);
    end
  endtask

  task automatic test_mid_reset();
    int n, stray;
    bit e_err, e_vld;
    logic [31:0] e_rd;
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h1234_5678, e_err, e_vld, e_rd);
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h4, 32'hCAFE_F00D, e_err, e_vld, e_rd);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b1 || bus.test_value !== '0 || bus.r_data !== '0) begin
      bad++; $display("FAIL reset_again: busy=%b test_value=%h r_data=%h, want 1 0 0",
                      bus.busy, bus.test_value, bus.r_data);
    end
    @(negedge clk) reset = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL busy_at_100: got %b, want 1", bus.busy); end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    count_clear(n, stray);
    model_clear();
    total++;
    if (n != 256 || stray != 0) begin
      bad++; $display("FAIL restart_clear: busy %0d cycles stray %0d, want 256 0", n, stray);
    end
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'(4 * i), 32'h0, e_err, e_vld, e_rd);
      total++;
      if (bus.r_valid !== 1'b1 || bus.r_data !== 32'h0) begin
        bad++; $display("FAIL preload_cleared%0d: r_valid=%b r_data=%h, want 1 00000000",
                        i, bus.r_valid, bus.r_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit e_err, e_vld;
    logic [31:0] e_rd, v;
    v = $urandom;
    for (int i = 0; i < 16; i++) begin
      issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, v + 32'(i), e_err, e_vld, e_rd);
      total++;
      if (bus.r_valid !== 1'b0 || bus.err !== 1'b0) begin
        bad++; $display("FAIL b2b_store%0d: r_valid=%b err=%b, want 0 0", i, bus.r_valid, bus.err);
      end
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, e_err, e_vld, e_rd);
      total++;
      if (bus.r_valid !== 1'b1 || bus.r_data !== v + 32'(i)) begin
        bad++; $display("FAIL b2b_load%0d: r_valid=%b r_data=%h, want 1 %h",
                        i, bus.r_valid, bus.r_data, v + 32'(i));
      end
    end
  endtask

  task automatic test_random();
    bit e_err, e_vld, rq, we, sx;
    logic [1:0] sz;
    logic [31:0] a, e_rd;
    for (int i = 0; i < 400; i++) begin
      rq = ($urandom_range(0, 9) != 0);
      we = 1'($urandom_range(0, 1));
      sx = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 19) == 0) ? 32'h400 + 32'($urandom_range(0, 4095))
                                        : 32'($urandom_range(0, 47));
      issue(rq, we, sz, sx, a, $urandom, e_err, e_vld, e_rd);
      total++;
      if (bus.err !== e_err || bus.r_valid !== e_vld || bus.r_data !== e_rd
          || bus.test_value !== model_tv() || (bus.err && bus.r_valid)) begin
        bad++;
        $display("FAIL random%0d a=%h sz=%0d we=%b: err=%b r_valid=%b r_data=%h tv=%h, want %b %b %h %h",
                 i, a, sz, we, bus.err, bus.r_valid, bus.r_data, bus.test_value,
                 e_err, e_vld, e_rd, model_tv());
      end
    end
  endtask

  initial begin
    bus.req = 1'b0; bus.w_en = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = 32'h0; bus.w_data = 32'h0;
    model_clear();
    test_reset();
    test_byte_loads();
    test_merge();
    test_errors();
    test_test_value();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
